// File: rtl/gpio_apb_pkg.sv
// gpio_apb_pkg
//   Shared definitions for the APB GPIO peripheral: the register byte
//   offsets decoded on PADDR, and a helper that applies a masked
//   half-word update to the output register.
//   No ports; imported by gpio_apb.
package gpio_apb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_IN     = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_OUT    = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_MLOW   = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_MHIGH  = 6'h0C;
  localparam logic [ADDR_W-1:0] ADDR_DIR    = 6'h10;
  localparam logic [ADDR_W-1:0] ADDR_IE     = 6'h14;
  localparam logic [ADDR_W-1:0] ADDR_EDGE   = 6'h18;
  localparam logic [ADDR_W-1:0] ADDR_IFG    = 6'h1C;
  localparam logic [ADDR_W-1:0] ADDR_STRAPV = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_STRAPD = 6'h24;
  localparam logic [ADDR_W-1:0] ADDR_TH0    = 6'h2C;
  localparam logic [ADDR_W-1:0] ADDR_TH1    = 6'h30;
  localparam logic [ADDR_W-1:0] ADDR_TH2    = 6'h34;
  localparam logic [ADDR_W-1:0] ADDR_TH3    = 6'h38;

  // Masked half-word write: the upper half of the write data is a per-bit
  // enable, the lower half the new value. Bits with a zero mask keep their
  // old value.
  function automatic logic [15:0] mask_merge(input logic [15:0] old_val,
                                             input logic [31:0] wdata);
    return (old_val & ~wdata[31:16]) | (wdata[15:0] & wdata[31:16]);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync
//   Multi-stage register chain used to bring the asynchronous pad inputs
//   into the PCLK domain. Stages=2 gives a classic two-flop synchronizer,
//   Stages=1 a single capture register for inputs already synchronous.
// Ports:
//   PCLK     in   clock
//   PRESETn  in   asynchronous active-low reset, clears every stage
//   d        in   Width-bit raw input
//   q        out  Width-bit synchronized output (last stage)
module gpio_sync #(
  parameter int Stages = 2,
  parameter int Width  = 32
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Stages];

  // Shift the input through the chain; stage 0 captures the raw value and
  // each later stage copies its predecessor.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < Stages; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < Stages; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[Stages-1];

endmodule

// File: rtl/gpio_apb.sv
// gpio_apb
//   32-bit GPIO peripheral behind an APB slave port. Holds the output and
//   direction registers driven to the pad ring, masked half-word output
//   updates, per-pin edge/level interrupts with write-one-to-clear flags,
//   a one-shot strap capture register and four scratch threshold registers.
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   stall                  request one APB wait state
//   err                    error indication, mirrored on PSLVERR
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR [5:0]            byte address
//   PWDATA [31:0]          write data
//   PRDATA [31:0]          combinational read data
//   PREADY, PSLVERR        APB response
//   gpio_in [31:0]         asynchronous pad inputs
//   strap_en               PCLK-synchronous strap capture strobe
//   gpio_out, gpio_dir     OUT / DIR registers (dir 1 = output)
//   irq                    OR of enabled pending flags
//   strap_sample_valid     STRAPV bit
//   strap_sample_data      STRAPD register
module gpio_apb
  import gpio_apb_pkg::*;
#(
  parameter bit AsyncOn = 1'b1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        stall,
  input  logic        err,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [5:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [31:0] gpio_in,
  input  logic        strap_en,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_dir,
  output logic        irq,
  output logic        strap_sample_valid,
  output logic [31:0] strap_sample_data
);

  localparam int SyncStages = AsyncOn ? 2 : 1;

  logic        waited;
  logic        wr_en;
  logic [31:0] sync_in;
  logic [31:0] sync_d;
  logic [31:0] out_reg;
  logic [31:0] dir_reg;
  logic [31:0] ie_reg;
  logic [31:0] edge_reg;
  logic [31:0] ifg_reg;
  logic [31:0] ifg_w1c;
  logic [31:0] ev;
  logic        strapv_reg;
  logic [31:0] strapd_reg;
  logic [31:0] th_reg [4];

  gpio_sync #(
    .Stages(SyncStages),
    .Width (32)
  ) u_sync (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .d      (gpio_in),
    .q      (sync_in)
  );

  // A stalled access phase sets the waited flag, which forces PREADY high
  // on the following cycle, so a stall costs at most one wait state.
  assign PREADY  = !stall || waited;
  assign PSLVERR = err;
  assign wr_en   = PSEL && PENABLE && PREADY && PWRITE && !err;

  // The flag drops once the transfer completes or the slave is deselected,
  // so the next transfer starts with a fresh stall decision.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      waited <= 1'b0;
    end else if (PSEL && PENABLE && !PREADY) begin
      waited <= 1'b1;
    end else if (!PSEL || (PENABLE && PREADY)) begin
      waited <= 1'b0;
    end
  end

  // Plain read/write configuration registers, including the masked
  // half-word update paths into OUT.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_reg  <= '0;
      dir_reg  <= '0;
      ie_reg   <= '0;
      edge_reg <= '0;
      for (int i = 0; i < 4; i++) begin
        th_reg[i] <= '0;
      end
    end else if (wr_en) begin
      case (PADDR)
        ADDR_OUT:   out_reg        <= PWDATA;
        ADDR_MLOW:  out_reg[15:0]  <= mask_merge(out_reg[15:0], PWDATA);
        ADDR_MHIGH: out_reg[31:16] <= mask_merge(out_reg[31:16], PWDATA);
        ADDR_DIR:   dir_reg        <= PWDATA;
        ADDR_IE:    ie_reg         <= PWDATA;
        ADDR_EDGE:  edge_reg       <= PWDATA;
        ADDR_TH0:   th_reg[0]      <= PWDATA;
        ADDR_TH1:   th_reg[1]      <= PWDATA;
        ADDR_TH2:   th_reg[2]      <= PWDATA;
        ADDR_TH3:   th_reg[3]      <= PWDATA;
        default:    ;
      endcase
    end
  end

  // Per-pin event: a rising edge of the synchronized input in edge mode,
  // otherwise the synchronized level itself.
  assign ev      = (edge_reg & sync_in & ~sync_d) | (~edge_reg & sync_in);
  assign ifg_w1c = (wr_en && (PADDR == ADDR_IFG)) ? PWDATA : '0;

  // Interrupt flags: the set term is ORed in after the clear so a new event
  // in the same cycle as a W1C keeps the flag pending.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_d  <= '0;
      ifg_reg <= '0;
    end else begin
      sync_d  <= sync_in;
      ifg_reg <= (ifg_reg & ~ifg_w1c) | (ev & ie_reg);
    end
  end

  // Strap capture samples the raw pads, since straps are static while the
  // strobe is asserted. A capture takes priority over a simultaneous clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      strapv_reg <= 1'b0;
      strapd_reg <= '0;
    end else if (strap_en) begin
      strapv_reg <= 1'b1;
      strapd_reg <= gpio_in;
    end else if (wr_en && (PADDR == ADDR_STRAPV) && PWDATA[0]) begin
      strapv_reg <= 1'b0;
    end
  end

  // Read mux; write-only and unmapped offsets return zero.
  always_comb begin
    PRDATA = '0;
    case (PADDR)
      ADDR_IN:     PRDATA = sync_in;
      ADDR_OUT:    PRDATA = out_reg;
      ADDR_DIR:    PRDATA = dir_reg;
      ADDR_IE:     PRDATA = ie_reg;
      ADDR_EDGE:   PRDATA = edge_reg;
      ADDR_IFG:    PRDATA = ifg_reg;
      ADDR_STRAPV: PRDATA = {31'b0, strapv_reg};
      ADDR_STRAPD: PRDATA = strapd_reg;
      ADDR_TH0:    PRDATA = th_reg[0];
      ADDR_TH1:    PRDATA = th_reg[1];
      ADDR_TH2:    PRDATA = th_reg[2];
      ADDR_TH3:    PRDATA = th_reg[3];
      default:     PRDATA = '0;
    endcase
  end

  assign gpio_out           = out_reg;
  assign gpio_dir           = dir_reg;
  assign irq                = |(ifg_reg & ie_reg);
  assign strap_sample_valid = strapv_reg;
  assign strap_sample_data  = strapd_reg;

endmodule

// File: tb/tb_gpio_apb.sv
// tb_gpio_apb
//   Self-checking bench for gpio_apb: a table of directed register
//   accesses with hand-computed read values, followed by hand-written
//   sequences for wait states, error handling, interrupts, strap capture,
//   input synchronizer latency and reset during a transfer.
module tb_gpio_apb;
  import gpio_apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        stall;
  logic        err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [5:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] gpio_in;
  logic        strap_en;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;
  logic        irq;
  logic        strap_sample_valid;
  logic [31:0] strap_sample_data;

  int          compared   = 0;
  int          mismatched = 0;
  int          lastWaits;
  logic [31:0] lastRdata;
  logic        lastSlverr;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  gpio_apb #(
    .AsyncOn(1'b1)
  ) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .stall             (stall),
    .err               (err),
    .PSEL              (PSEL),
    .PENABLE           (PENABLE),
    .PWRITE            (PWRITE),
    .PADDR             (PADDR),
    .PWDATA            (PWDATA),
    .PRDATA            (PRDATA),
    .PREADY            (PREADY),
    .PSLVERR           (PSLVERR),
    .gpio_in           (gpio_in),
    .strap_en          (strap_en),
    .gpio_out          (gpio_out),
    .gpio_dir          (gpio_dir),
    .irq               (irq),
    .strap_sample_valid(strap_sample_valid),
    .strap_sample_data (strap_sample_data)
  );

  // Free-running 100 MHz clock.
  always #5 PCLK = ~PCLK;

  // Safety net so a stuck run still terminates with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value and keep the counts.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  // One complete APB transfer; records wait states, read data and PSLVERR
  // as seen in the completing access cycle.
  task automatic apbTransfer(input logic wr, input logic [5:0] addr,
                             input logic [31:0] wdata);
    int n;
    @(posedge PCLK); #1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    while (!PREADY && n < 8) begin
      @(posedge PCLK); #1;
      n++;
    end
    lastWaits = n;
    if (!PREADY) begin
      checkOutput("pready_timeout", {31'b0, PREADY}, 32'd1);
    end
    lastRdata  = PRDATA;
    lastSlverr = PSLVERR;
    @(posedge PCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  // Apply one table entry: writes just go out, reads are compared.
  task automatic applyStimulus(input vec_t v, input int idx);
    apbTransfer(v.wr, v.addr, v.wr ? v.data : 32'h0);
    if (!v.wr) begin
      checkOutput($sformatf("vec%0d_rd_%02h", idx, v.addr), lastRdata, v.data);
    end
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
    apbTransfer(1'b0, addr, 32'h0);
    checkOutput(name, lastRdata, exp);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    apbTransfer(1'b1, addr, data);
  endtask

  initial begin
    int n;
    PRESETn  = 1'b0;
    stall    = 1'b0;
    err      = 1'b0;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = '0;
    PWDATA   = '0;
    gpio_in  = '0;
    strap_en = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("rst_gpio_out", gpio_out, 32'h0);
    checkOutput("rst_gpio_dir", gpio_dir, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_strapv", {31'b0, strap_sample_valid}, 32'h0);
    checkOutput("rst_strapd", strap_sample_data, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    checkOutput("rst_pready", {31'b0, PREADY}, 32'h1);

    // Directed register table, pads held at zero so no interrupts fire.
    vecs.push_back('{1'b1, ADDR_OUT,    32'h0000_0000});
    vecs.push_back('{1'b1, ADDR_MLOW,   32'hFFFF_1234});
    vecs.push_back('{1'b0, ADDR_OUT,    32'h0000_1234});
    vecs.push_back('{1'b1, ADDR_MHIGH,  32'h0FF0_ABCD});
    vecs.push_back('{1'b0, ADDR_OUT,    32'h0BC0_1234});
    vecs.push_back('{1'b0, ADDR_MLOW,   32'h0000_0000});
    vecs.push_back('{1'b0, ADDR_MHIGH,  32'h0000_0000});
    vecs.push_back('{1'b1, ADDR_OUT,    32'hFFFF_0000});
    vecs.push_back('{1'b1, ADDR_MLOW,   32'h00F0_00AB});
    vecs.push_back('{1'b0, ADDR_OUT,    32'hFFFF_00A0});
    vecs.push_back('{1'b1, ADDR_DIR,    32'hA5A5_A5A5});
    vecs.push_back('{1'b0, ADDR_DIR,    32'hA5A5_A5A5});
    vecs.push_back('{1'b1, ADDR_IE,     32'h0000_FFFF});
    vecs.push_back('{1'b0, ADDR_IE,     32'h0000_FFFF});
    vecs.push_back('{1'b1, ADDR_EDGE,   32'h1234_5678});
    vecs.push_back('{1'b0, ADDR_EDGE,   32'h1234_5678});
    vecs.push_back('{1'b1, ADDR_TH0,    32'h0000_0000});
    vecs.push_back('{1'b1, ADDR_TH1,    32'h1111_1111});
    vecs.push_back('{1'b1, ADDR_TH2,    32'h2222_2222});
    vecs.push_back('{1'b1, ADDR_TH3,    32'h3333_3333});
    vecs.push_back('{1'b0, ADDR_TH0,    32'h0000_0000});
    vecs.push_back('{1'b0, ADDR_TH1,    32'h1111_1111});
    vecs.push_back('{1'b0, ADDR_TH2,    32'h2222_2222});
    vecs.push_back('{1'b0, ADDR_TH3,    32'h3333_3333});
    vecs.push_back('{1'b1, 6'h28,       32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 6'h28,       32'h0000_0000});
    vecs.push_back('{1'b1, ADDR_STRAPD, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, ADDR_STRAPD, 32'h0000_0000});
    vecs.push_back('{1'b0, ADDR_IFG,    32'h0000_0000});
    vecs.push_back('{1'b1, ADDR_IE,     32'h0000_0000});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end
    checkOutput("port_gpio_out", gpio_out, 32'hFFFF_00A0);
    checkOutput("port_gpio_dir", gpio_dir, 32'hA5A5_A5A5);

    $display("[TB] wait-state and error handling");
    stall = 1'b1;
    wr(ADDR_OUT, 32'hDEAD_BEEF);
    checkOutput("stall_waits", lastWaits, 32'd1);
    rd(ADDR_OUT, 32'hDEAD_BEEF, "stall_rd_out");
    checkOutput("stall_rd_waits", lastWaits, 32'd1);
    stall = 1'b0;
    rd(ADDR_OUT, 32'hDEAD_BEEF, "nostall_rd_out");
    checkOutput("nostall_waits", lastWaits, 32'd0);
    err = 1'b1;
    apbTransfer(1'b0, ADDR_OUT, 32'h0);
    checkOutput("err_pslverr", {31'b0, lastSlverr}, 32'h1);
    wr(ADDR_OUT, 32'h1111_1111);
    err = 1'b0;
    rd(ADDR_OUT, 32'hDEAD_BEEF, "err_wr_discarded");
    checkOutput("noerr_pslverr", {31'b0, lastSlverr}, 32'h0);

    $display("[TB] edge and level interrupts");
    wr(ADDR_EDGE, 32'h0000_0001);
    wr(ADDR_IE,   32'h0000_0001);
    @(posedge PCLK); #1;
    gpio_in = 32'h0000_0001;
    n = 0;
    while (!irq && n < 3) begin
      @(posedge PCLK); #1;
      n++;
    end
    checkOutput("edge_irq", {31'b0, irq}, 32'h1);
    rd(ADDR_IFG, 32'h0000_0001, "edge_ifg_set");
    wr(ADDR_IFG, 32'h0000_0001);
    rd(ADDR_IFG, 32'h0000_0000, "edge_ifg_cleared");
    checkOutput("edge_irq_cleared", {31'b0, irq}, 32'h0);
    wr(ADDR_EDGE, 32'h0000_0000);
    wr(ADDR_IFG,  32'h0000_0001);
    rd(ADDR_IFG, 32'h0000_0001, "level_set_beats_clear");
    checkOutput("level_irq", {31'b0, irq}, 32'h1);
    wr(ADDR_IE,  32'h0000_0000);
    wr(ADDR_IFG, 32'h0000_0001);
    rd(ADDR_IFG, 32'h0000_0000, "level_ifg_cleared");
    checkOutput("level_irq_off", {31'b0, irq}, 32'h0);

    $display("[TB] strap capture");
    gpio_in = 32'hCAFE_BABE;
    @(posedge PCLK); #1;
    strap_en = 1'b1;
    @(posedge PCLK); #1;
    strap_en = 1'b0;
    checkOutput("strap_valid_port", {31'b0, strap_sample_valid}, 32'h1);
    checkOutput("strap_data_port", strap_sample_data, 32'hCAFE_BABE);
    rd(ADDR_STRAPV, 32'h0000_0001, "strapv_set");
    rd(ADDR_STRAPD, 32'hCAFE_BABE, "strapd_data");
    wr(ADDR_STRAPV, 32'h0000_0001);
    rd(ADDR_STRAPV, 32'h0000_0000, "strapv_cleared");
    rd(ADDR_STRAPD, 32'hCAFE_BABE, "strapd_kept");
    gpio_in  = 32'h1357_2468;
    strap_en = 1'b1;
    wr(ADDR_STRAPV, 32'h0000_0001);
    strap_en = 1'b0;
    rd(ADDR_STRAPV, 32'h0000_0001, "strap_set_beats_clear");
    rd(ADDR_STRAPD, 32'h1357_2468, "strapd_recapture");

    $display("[TB] input synchronizer latency");
    PADDR = ADDR_IN;
    @(posedge PCLK); #1;
    checkOutput("in_before", PRDATA, 32'h1357_2468);
    gpio_in = 32'h1234_ABCD;
    @(posedge PCLK); #1;
    checkOutput("in_after_1", PRDATA, 32'h1357_2468);
    @(posedge PCLK); #1;
    checkOutput("in_after_2", PRDATA, 32'h1234_ABCD);

    $display("[TB] reset during a stalled write");
    wr(ADDR_DIR, 32'h0000_00FF);
    stall = 1'b1;
    @(posedge PCLK); #1;
    PSEL   = 1'b1;
    PWRITE = 1'b1;
    PADDR  = ADDR_OUT;
    PWDATA = 32'h5555_AAAA;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("midrst_gpio_out", gpio_out, 32'h0);
    checkOutput("midrst_gpio_dir", gpio_dir, 32'h0);
    checkOutput("midrst_strapv", {31'b0, strap_sample_valid}, 32'h0);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    stall   = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    rd(ADDR_OUT, 32'h0000_0000, "postrst_out");
    rd(ADDR_TH1, 32'h0000_0000, "postrst_th1");
    rd(ADDR_STRAPD, 32'h0000_0000, "postrst_strapd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
